sync_fifo_dir: RTL and testbench

- Single-clock, parametrised FIFO with storage, pointers and status logic in one block.
- Full/empty are resolved with a registered direction flag instead of an extra pointer bit, so pointers are ADDRSIZE wide.
- Adds capabilities beyond the basic pointer-comparison scheme: fill count, programmable almost-full/almost-empty, and sticky overflow/underflow error flags.
- Sits between a producer and a consumer in the same clock domain.

---
 rtl/sync_fifo_dir_pkg.sv | 18 +
 rtl/sync_fifo_dir_mem.sv | 29 ++
 rtl/sync_fifo_dir.sv | 107 ++++++++++
 tb/tb_sync_fifo_dir.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_dir_pkg.sv
// Shared definitions for the direction-flag synchronous FIFO:
// depth/count-width derivation and the reset values of the status flags.
package sync_fifo_dir_pkg;

  localparam logic RST_WFULL  = 1'b0;
  localparam logic RST_REMPTY = 1'b1;
  localparam logic RST_DIR    = 1'b0;
  localparam logic RST_ERR    = 1'b0;

  function automatic int unsigned fifo_depth(input int unsigned addrsize);
    return 32'd1 << addrsize;
  endfunction

  function automatic int unsigned count_width(input int unsigned addrsize);
    return addrsize + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_dir_mem.sv
// FIFO storage: DEPTH x DATASIZE array with a synchronous write port and an
// asynchronous read port, so the head word falls through to the read side.
module sync_fifo_mem
  import sync_fifo_dir_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                clk_i,
  input  logic                wclken_i,
  input  logic [ADDRSIZE-1:0] waddr_i,
  input  logic [DATASIZE-1:0] wdata_i,
  input  logic [ADDRSIZE-1:0] raddr_i,
  output logic [DATASIZE-1:0] rdata_o
);

  logic [DATASIZE-1:0] mem_q [fifo_depth(ADDRSIZE)];

  // Store the incoming word at the write address when the write is accepted.
  always_ff @(posedge clk_i) begin
    if (wclken_i) mem_q[waddr_i] <= wdata_i;
  end

  // Combinational read of the word at the read address.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/sync_fifo_dir.sv
// Single-clock FIFO with ADDRSIZE-wide pointers; full vs. empty on pointer
// equality is resolved by a registered direction flag. Also provides an
// occupancy count, programmable almost-full/almost-empty and sticky errors.
module sync_fifo_dir
  import sync_fifo_dir_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  output logic                wfull,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                rempty,
  input  logic [ADDRSIZE:0]   afull_thresh,
  input  logic [ADDRSIZE:0]   aempty_thresh,
  output logic                afull,
  output logic                aempty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow,
  input  logic                clr_err
);

  localparam int unsigned CW = count_width(ADDRSIZE);

  logic [ADDRSIZE-1:0] wptr_q, wptr_d;
  logic [ADDRSIZE-1:0] rptr_q, rptr_d;
  logic                dir_q, dir_d;
  logic                wfull_q, wfull_d;
  logic                rempty_q, rempty_d;
  logic [CW-1:0]       count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                we, re;

  // Accept decisions use the registered flags; next-state for all status.
  always_comb begin
    we       = winc & ~wfull_q;
    re       = rinc & ~rempty_q;
    wptr_d   = wptr_q + ADDRSIZE'(we);
    rptr_d   = rptr_q + ADDRSIZE'(re);
    dir_d    = dir_q;
    count_d  = count_q;
    case ({we, re})
      2'b10: begin dir_d = 1'b1; count_d = count_q + CW'(1); end
      2'b01: begin dir_d = 1'b0; count_d = count_q - CW'(1); end
      default: ;
    endcase
    wfull_d  = (wptr_d == rptr_d) &  dir_d;
    rempty_d = (wptr_d == rptr_d) & ~dir_d;
    ovf_d    = (ovf_q & ~clr_err) | (winc & wfull_q);
    unf_d    = (unf_q & ~clr_err) | (rinc & rempty_q);
  end

  // Register pointers, direction, flags, count and sticky errors.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      dir_q    <= RST_DIR;
      wfull_q  <= RST_WFULL;
      rempty_q <= RST_REMPTY;
      count_q  <= '0;
      ovf_q    <= RST_ERR;
      unf_q    <= RST_ERR;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      dir_q    <= dir_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Threshold compares on the registered count; thresholds may change freely.
  always_comb begin
    afull  = (count_q >= afull_thresh);
    aempty = (count_q <= aempty_thresh);
  end

  assign wfull     = wfull_q;
  assign rempty    = rempty_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  // Writes during the reset cycle are suppressed so no data lands in memory.
  sync_fifo_mem #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_mem (
    .clk_i    (clk),
    .wclken_i (we & rst_n),
    .waddr_i  (wptr_q),
    .wdata_i  (wdata),
    .raddr_i  (rptr_q),
    .rdata_o  (rdata)
  );

endmodule

// File: tb/tb_sync_fifo_dir.sv
// Self-checking bench for sync_fifo_dir (DATASIZE=8, ADDRSIZE=4).
// Reference model: a data queue plus sticky error bits.
module tb_sync_fifo_dir;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n, winc, rinc, clr_err;
  logic [DW-1:0] wdata, rdata;
  logic          wfull, rempty, afull, aempty, overflow, underflow;
  logic [AW:0]   afull_thresh, aempty_thresh, count;

  always #5 clk = ~clk;

  sync_fifo_dir #(
    .DATASIZE (DW),
    .ADDRSIZE (AW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .winc          (winc),
    .wdata         (wdata),
    .wfull         (wfull),
    .rinc          (rinc),
    .rdata         (rdata),
    .rempty        (rempty),
    .afull_thresh  (afull_thresh),
    .aempty_thresh (aempty_thresh),
    .afull         (afull),
    .aempty        (aempty),
    .count         (count),
    .overflow      (overflow),
    .underflow     (underflow),
    .clr_err       (clr_err)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mq[$];
  bit            m_ovf, m_unf;

  typedef struct {
    logic          w;
    logic [DW-1:0] d;
    logic          r;
    logic          c;
    logic          rn;
    int            e_count;
    logic          e_full;
    logic          e_empty;
    logic          e_afull;
    logic          e_aempty;
    logic [DW-1:0] e_rdata;
    logic          e_ovf;
    logic          e_unf;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Drive inputs (called at negedge), advance one edge, update the model,
  // and return at the following negedge for sampling.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic c, input logic rn);
    bit full, empty;
    winc = w; wdata = d; rinc = r; clr_err = c; rst_n = rn;
    @(posedge clk);
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    if (!rn) begin
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      m_ovf = (m_ovf && !c) || (w && full);
      m_unf = (m_unf && !c) || (r && empty);
      if (r && !empty) void'(mq.pop_front());
      if (w && !full) mq.push_back(d);
    end
    @(negedge clk);
    winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; rst_n = 1'b1;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"},     int'(count),     n);
    chk({tag, ".wfull"},     int'(wfull),     int'(n == DEPTH));
    chk({tag, ".rempty"},    int'(rempty),    int'(n == 0));
    chk({tag, ".afull"},     int'(afull),     int'(n >= int'(afull_thresh)));
    chk({tag, ".aempty"},    int'(aempty),    int'(n <= int'(aempty_thresh)));
    chk({tag, ".overflow"},  int'(overflow),  int'(m_ovf));
    chk({tag, ".underflow"}, int'(underflow), int'(m_unf));
    if (n > 0) chk({tag, ".rdata"}, int'(rdata), int'(mq[0]));
  endtask

  initial begin
    rst_n = 1'b0; winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; wdata = '0;
    afull_thresh = '0; aempty_thresh = '0;
    @(negedge clk);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Reset state, with afull_thresh=0 so afull reads 1 on an empty FIFO
    chk("rst.count",  int'(count), 0);
    chk("rst.rempty", int'(rempty), 1);
    chk("rst.wfull",  int'(wfull), 0);
    chk("rst.afull",  int'(afull), 1);
    chk("rst.aempty", int'(aempty), 1);
    chk("rst.ovf",    int'(overflow), 0);
    chk("rst.unf",    int'(underflow), 0);

    // Table vectors: afull = count>=1, aempty = count<=0
    afull_thresh = 5'd1; aempty_thresh = 5'd0;
    //           w  d      r  c  rn cnt F  E  AF AE rdata  ovf unf
    vt[0] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0};
    vt[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
    vt[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[4] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 1'b0, 1'b1};
    vt[5] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 1'b0, 1'b1};
    vt[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 1'b0, 1'b0};
    vt[7] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      step(vt[i].w, vt[i].d, vt[i].r, vt[i].c, vt[i].rn);
      chk($sformatf("vec%0d.count", i),  int'(count),     vt[i].e_count);
      chk($sformatf("vec%0d.wfull", i),  int'(wfull),     int'(vt[i].e_full));
      chk($sformatf("vec%0d.rempty", i), int'(rempty),    int'(vt[i].e_empty));
      chk($sformatf("vec%0d.afull", i),  int'(afull),     int'(vt[i].e_afull));
      chk($sformatf("vec%0d.aempty", i), int'(aempty),    int'(vt[i].e_aempty));
      chk($sformatf("vec%0d.ovf", i),    int'(overflow),  int'(vt[i].e_ovf));
      chk($sformatf("vec%0d.unf", i),    int'(underflow), int'(vt[i].e_unf));
      if (!vt[i].e_empty) chk($sformatf("vec%0d.rdata", i), int'(rdata), int'(vt[i].e_rdata));
    end

    // Fill 0x00..0x0F with thresholds 12/3: afull at 12, aempty drops at 4
    afull_thresh = 5'd12; aempty_thresh = 5'd3;
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 8'(i), 0, 0, 1);
      chk("fill.count",  int'(count), i + 1);
      chk("fill.afull",  int'(afull), int'(i + 1 >= 12));
      chk("fill.aempty", int'(aempty), int'(i + 1 <= 3));
      check_model("fill");
    end
    chk("fill.wfull", int'(wfull), 1);

    // Write attempt while full sets overflow, count holds
    step(1, 8'hAA, 0, 0, 1);
    chk("ovf.flag",  int'(overflow), 1);
    chk("ovf.count", int'(count), DEPTH);

    // Full with winc & rinc: read only, count to DEPTH-1
    step(1, 8'hBB, 1, 1, 1);
    chk("fullboth.count", int'(count), DEPTH - 1);
    chk("fullboth.ovf",   int'(overflow), 1);
    for (int i = 1; i < DEPTH; i++) begin
      chk("drain.rdata", int'(rdata), i);
      step(0, 8'h00, 1, 0, 1);
      check_model("drain");
    end
    chk("drain.rempty", int'(rempty), 1);

    // Occupancy 8, 40 cycles of simultaneous read/write, pointers wrap
    step(0, 8'h00, 0, 1, 1);
    for (int i = 0; i < 8; i++) step(1, 8'(8'h80 + i), 0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      chk("stream.rdata", int'(rdata), 8'h80 + i);
      step(1, 8'(8'h88 + i), 1, 0, 1);
      chk("stream.count", int'(count), 8);
      check_model("stream");
    end

    // Reset at occupancy 9
    step(1, 8'h11, 0, 0, 1);
    chk("mid.count9", int'(count), 9);
    step(1, 8'h22, 1, 0, 0);
    chk("mid.count",  int'(count), 0);
    chk("mid.rempty", int'(rempty), 1);
    chk("mid.wfull",  int'(wfull), 0);
    chk("mid.ovf",    int'(overflow), 0);
    chk("mid.unf",    int'(underflow), 0);

    // Randomized traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      if ((i % 50) == 0) begin
        afull_thresh  = 5'($urandom_range(0, 31));
        aempty_thresh = 5'($urandom_range(0, 31));
      end
      step(1'($urandom_range(0, 99) < 55), 8'($urandom),
           1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 199) != 0));
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
